// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle ops and iterative mul/div behind ALU_SEQ_MULDIV_EN
// Without ALU_SEQ_MULDIV_EN, ops 10-15 finish in one cycle flagged illegal.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [1:0]      state;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] imm_res;
  logic            imm_ill;
  logic            go_busy;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign shamt     = src2[SHW-1:0];

  always_comb begin
    fast_res = '0;
    case (op)
      OP_ADD:  fast_res = src1 + src2;
      OP_SUB:  fast_res = src1 - src2;
      OP_AND:  fast_res = src1 & src2;
      OP_OR:   fast_res = src1 | src2;
      OP_XOR:  fast_res = src1 ^ src2;
      OP_SLL:  fast_res = src1 << shamt;
      OP_SRL:  fast_res = src1 >> shamt;
      OP_SRA:  fast_res = $signed(src1) >>> shamt;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      default: fast_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  // acc_hi/acc_lo: product high/low for multiply, remainder/quotient for divide
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] divisor;
  logic [3:0]      op_q;
  logic [SHW:0]    cnt;
  logic            last;
  logic            neg_q;
  logic            neg_r;

  logic            is_md;
  logic            is_div;
  logic            signed_div;
  logic            src1_neg;
  logic            src2_neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] final_res;

  assign is_md      = (op >= OP_MUL);
  assign is_div     = (op >= OP_DIV);
  assign signed_div = (op == OP_DIV) || (op == OP_REM);
  assign src1_neg   = signed_div && src1[XLEN-1];
  assign src2_neg   = signed_div && src2[XLEN-1];
  assign mag1       = src1_neg ? -src1 : src1;
  assign mag2       = src2_neg ? -src2 : src2;
  assign div_zero   = is_div && (src2 == '0);
  assign div_ovf    = signed_div && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign go_busy    = is_md && !div_zero && !div_ovf;
  assign imm_ill    = 1'b0;

  always_comb begin
    imm_res = fast_res;
    if (div_zero)
      imm_res = (op == OP_DIV || op == OP_DIVU) ? '1 : src1;
    else if (div_ovf)
      imm_res = (op == OP_DIV) ? src1 : '0;
  end

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
  assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, divisor};
  assign div_ge   = !div_diff[XLEN];

  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:          final_res = acc_lo;
      OP_MULHU:        final_res = acc_hi;
      OP_DIV, OP_DIVU: final_res = neg_q ? -acc_lo : acc_lo;
      OP_REM, OP_REMU: final_res = neg_r ? -acc_hi : acc_hi;
      default:         final_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      divisor   <= '0;
      op_q      <= '0;
      cnt       <= '0;
      last      <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
      last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (go_busy) begin
              state   <= S_BUSY;
              op_q    <= op;
              acc_hi  <= '0;
              acc_lo  <= mag1;
              divisor <= mag2;
              neg_q   <= src1_neg ^ src2_neg;
              neg_r   <= src1_neg;
              cnt     <= '0;
              last    <= 1'b0;
            end else begin
              state     <= S_DONE;
              result_q  <= imm_res;
              zero_q    <= (imm_res == '0);
              illegal_q <= imm_ill;
            end
          end
        end
        S_BUSY: begin
          if (last) begin
            // extra cycle after the XLEN steps applies the sign correction
            state     <= S_DONE;
            result_q  <= final_res;
            zero_q    <= (final_res == '0);
            illegal_q <= 1'b0;
            last      <= 1'b0;
            cnt       <= '0;
          end else begin
            if (op_q >= OP_DIV) begin
              acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            if (cnt == (SHW+1)'(XLEN-1))
              last <= 1'b1;
            else
              cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign go_busy = 1'b0;
  assign imm_ill = (op >= OP_MUL);
  assign imm_res = imm_ill ? '0 : fast_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !go_busy) begin
            state     <= S_DONE;
            result_q  <= imm_res;
            zero_q    <= (imm_res == '0);
            illegal_q <= imm_ill;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven checks for alu_seq, mul/div vectors when ALU_SEQ_MULDIV_EN is defined
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_fail = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [3:0] o, logic [31:0] a, logic [31:0] b,
                              logic [31:0] r, logic z, logic il, int lat);
    vec_t v;
    v.name = nm; v.op = o; v.a = a; v.b = b; v.res = r; v.z = z; v.ill = il; v.lat = lat;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(vec_t v, int hold);
    int lat;
    @(negedge clk);
    chk({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; src1 = 32'h1234_5678; src2 = 32'h0000_0003; op = 4'd0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, ".result"}, result, v.res);
    chk({v.name, ".zero"}, 32'(zero), 32'(v.z));
    chk({v.name, ".illegal"}, 32'(illegal), 32'(v.ill));
    for (int i = 0; i < hold; i++) begin
      // a request offered while DONE must be ignored
      in_valid = 1'b1; op = 4'd0; src1 = 32'd7; src2 = 32'd9;
      @(negedge clk);
      chk({v.name, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, ".hold_result"}, result, v.res);
      chk({v.name, ".hold_illegal"}, 32'(illegal), 32'(v.ill));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({v.name, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({v.name, ".post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs.push_back(mk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1));
    vecs.push_back(mk("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1'b0, 1'b0, 1));
    vecs.push_back(mk("or", 4'd3, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0, 1'b0, 1));
    vecs.push_back(mk("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1));
    vecs.push_back(mk("sll_mask", 4'd5, 32'd1, 32'h0000_0021, 32'd2, 1'b0, 1'b0, 1));
    vecs.push_back(mk("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1));
    vecs.push_back(mk("sra_mask", 4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1));
    vecs.push_back(mk("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1));
    vecs.push_back(mk("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1));
    vecs.push_back(mk("slt_ge", 4'd8, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 1));
`ifdef ALU_SEQ_MULDIV_EN
    vecs.push_back(mk("mul", 4'd10, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 33));
    vecs.push_back(mk("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
    vecs.push_back(mk("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 33));
    vecs.push_back(mk("rem_neg", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33));
    vecs.push_back(mk("divu", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33));
    vecs.push_back(mk("remu", 4'd15, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33));
    vecs.push_back(mk("divu_by0", 4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1));
    vecs.push_back(mk("remu_by0", 4'd15, 32'd7, 32'd0, 32'd7, 1'b0, 1'b0, 1));
    vecs.push_back(mk("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1));
    vecs.push_back(mk("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1));
`else
    for (int o = 10; o < 16; o++)
      vecs.push_back(mk($sformatf("md_off_%0d", o), 4'(o), 32'd12, 32'd5, 32'd0, 1'b1, 1'b1, 1));
`endif

    #2;
    chk("rst.result", result, 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], 0);

`ifndef ALU_SEQ_MULDIV_EN
    run_op(mk("illegal_hold", 4'd10, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1), 5);
`else
    run_op(mk("add_hold", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1), 5);
`endif

    // flush wins over a simultaneous acceptance
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 4'd0; src1 = 32'd1; src2 = 32'd1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_accept.out_valid", 32'(out_valid), 32'd0);
      chk("flush_accept.in_ready", 32'(in_ready), 32'd1);
    end

    // flush while DONE drops out_valid
    in_valid = 1'b1; op = 4'd3; src1 = 32'd8; src2 = 32'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush_done.pre_valid", 32'(out_valid), 32'd1);
    chk("flush_done.pre_result", result, 32'd9);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done.out_valid", 32'(out_valid), 32'd0);
    chk("flush_done.in_ready", 32'(in_ready), 32'd1);

    // reset acts without waiting for a clock edge
    in_valid = 1'b1; op = 4'd0; src1 = 32'd5; src2 = 32'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("async_rst.pre_result", result, 32'd11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.result", result, 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SEQ_MULDIV_EN
    // flush ten cycles into a multiply
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("mul_flush.in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mul_flush.no_valid", 32'(seen), 32'd0);
    end

    // reset while BUSY discards the division
    in_valid = 1'b1; op = 4'd12; src1 = 32'd100; src2 = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("busy_rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("busy_rst.no_valid", 32'(seen), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; not overridden by instantiators.
REQ-003 The block SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have in_valid  input  1  operation request.
REQ-006 The block SHALL have in_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-008 The block SHALL have src1, src2  input  XLEN each  operands (src2 carries rs2 or sign-extended immediate).
REQ-009 The block SHALL have flush  input  1  abort any operation in progress.
REQ-010 The block SHALL have out_valid  output  1  result available.
REQ-011 The block SHALL have out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have result  output  XLEN  registered result.
REQ-013 The block SHALL have zero  output  1  registered, high when result == 0.
REQ-014 The block SHALL have illegal  output  1  registered, high when op was not executed (see REQ-031).

Function
REQ-015 The block SHALL implement states IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-016 A request SHALL be accepted when in_valid && in_ready; op and operands are captured at acceptance.
REQ-017 Ops 0-9 SHALL complete in one cycle: IDLE->DONE, out_valid high the cycle after acceptance.
REQ-018 Shifts SHALL use src2[SHW-1:0] only; SRA SHALL fill with src1[XLEN-1], e.g. SRA(0x80000000,4)=0xF8000000.
REQ-019 SLT/SLTU SHALL return 1 or 0 zero-extended to XLEN, signed/unsigned compare respectively; ADD/SUB wrap modulo 2^XLEN.
REQ-020 Ops 10-15 SHALL be iterative: IDLE->BUSY, one bit per cycle for XLEN cycles, then DONE; out_valid high exactly XLEN+1 cycles after acceptance.
REQ-021 MUL SHALL return low XLEN bits of the product; MULHU the high XLEN bits of the unsigned product.
REQ-022 DIV/REM SHALL operate on magnitudes with restoring division; quotient negated when operand signs differ, remainder takes sign of src1.
REQ-023 Divide by zero SHALL complete in one cycle (IDLE->DONE): DIV/DIVU return all ones, REM/REMU return src1.
REQ-024 Signed overflow (src1 = -2^(XLEN-1), src2 = -1) SHALL complete in one cycle: DIV returns src1, REM returns 0.
REQ-025 In DONE, result/zero/illegal SHALL hold stable until out_valid && out_ready; then DONE->IDLE next cycle.
REQ-026 flush SHALL force IDLE on the next edge from any state, drop out_valid, and produce no result; flush has priority over acceptance and completion in the same cycle.
REQ-027 An in_valid during BUSY or DONE SHALL be ignored (not captured) since in_ready is low.
REQ-028 The iteration counter SHALL be SHW+1 bits, counting 0..XLEN-1 with no wrap observable.

Reset
REQ-029 On rst_n low the block SHALL asynchronously enter IDLE, clear counter and datapath registers, drive result=0, zero=0, illegal=0, out_valid=0; in_ready=1 while in reset and after release.
REQ-030 Reset asserted during BUSY SHALL discard the operation; no out_valid follows release.

Configuration
REQ-031 Macro ALU_SEQ_MULDIV_EN SHALL compile ops 10-15 in; when undefined, ops 10-15 complete in one cycle with result=0, illegal=1, and no multiplier/divider logic or BUSY state is synthesised.

Verification
REQ-032 ADD 0xFFFFFFFF+1 -> out_valid cycle after accept, result 0, zero 1.
REQ-033 SRA 0x80000000 by src2=0x24 -> shift 4 used, result 0xF8000000.
REQ-034 DIV -7 / 2 (XLEN=32) -> out_valid at cycle 33, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-035 DIVU 5/0 -> out_valid next cycle, result 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
REQ-036 MUL start, flush at cycle 10 -> IDLE next cycle, no out_valid, in_ready 1.
REQ-037 Macro undefined, op=10 -> out_valid next cycle, result 0, illegal 1; hold out_ready low 5 cycles -> outputs stable.
